// File: rtl/egress_voq_scheduler_pkg.sv
// Shared types and defaults for the egress VOQ scheduler.
//   DEF_*         default build parameters (ports, pointer width, VOQ depth)
//   VOQ_CNT_W     width of an occupancy counter able to hold 0..VOQ_DEPTH
//   sched_entry_t one output-FIFO entry: buffer pointer, flood flag, source VOQ
package egress_voq_scheduler_pkg;

    localparam int DEF_N_PORTS   = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_VOQ_DEPTH = 4;
    localparam int VOQ_CNT_W     = $clog2(DEF_VOQ_DEPTH + 1);
    localparam int SRC_W         = $clog2(DEF_N_PORTS);

    // Field widths follow the package defaults; the top is built with those.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] ptr;
        logic                  flood;
        logic [SRC_W-1:0]      src;
    } sched_entry_t;

endpackage

// File: rtl/egress_voq_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr,
// wrapping modulo N. rr_ptr moves to grant+1 on the cycle advance is high.
//   clk, rst_n     clock, async active-low reset
//   req            request vector
//   advance        the current grant was taken this cycle
//   grant_onehot   one-hot grant (zero when no request)
//   grant_idx      binary index of the grant
//   any            at least one request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] rr_ptr;
    int            idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = IW'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/egress_voq_scheduler.sv
// Egress-side scheduler over one VOQ per ingress port. Mirrors each VOQ's
// occupancy from its write strobes, picks a non-empty VOQ round-robin,
// issues a one-cycle read, captures the returned pointer one cycle later
// into a 2-entry FIFO and presents it on a valid/ready interface.
//   clk, rst_n        clock, async active-low reset
//   voq_write_i       copy of each VOQ's write strobe
//   voq_read_o        one-hot read request to the chosen VOQ
//   voq_ptr_i/valid_i/flood_i  read response of each VOQ
//   pkt_ptr_o/flood_o/src_o/valid_o, pkt_ready_i  egress handshake
//   drop_o            pulse the cycle after a write hit a full VOQ
//   proto_err_o       sticky: a VOQ answered with no read in flight
module egress_voq_scheduler
    import egress_voq_scheduler_pkg::*;
#(
    parameter int N_PORTS   = DEF_N_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int VOQ_DEPTH = DEF_VOQ_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_PORTS-1:0]                 voq_write_i,
    output logic [N_PORTS-1:0]                 voq_read_o,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]     voq_ptr_i,
    input  logic [N_PORTS-1:0]                 voq_valid_i,
    input  logic [N_PORTS-1:0]                 voq_flood_i,
    output logic [ADDR_W-1:0]                  pkt_ptr_o,
    output logic                               pkt_flood_o,
    output logic [$clog2(N_PORTS)-1:0]         pkt_src_o,
    output logic                               pkt_valid_o,
    input  logic                               pkt_ready_i,
    output logic [N_PORTS-1:0]                 drop_o,
    output logic                               proto_err_o
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(VOQ_DEPTH + 1);

    logic [N_PORTS-1:0][CNT_W-1:0] cnt;
    logic [N_PORTS-1:0]            full, eligible, expect_vld, grant_oh;
    logic [IDX_W-1:0]              grant_idx, inflight_src;
    logic                          grant_any, inflight_vld;
    logic                          issue, push, pop, credit_ok;
    logic [1:0]                    reserved;

    sched_entry_t                  fifo_mem [2];
    sched_entry_t                  cap_entry, head;
    logic                          fifo_wr, fifo_rd;
    logic [1:0]                    fifo_cnt;

    always_comb begin
        full       = '0;
        eligible   = '0;
        expect_vld = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            full[i]       = (cnt[i] == CNT_W'(VOQ_DEPTH));
            eligible[i]   = (cnt[i] != '0);
            expect_vld[i] = inflight_vld && (inflight_src == IDX_W'(i));
        end
    end

    // Credit: a read reserves a FIFO slot from issue until its pointer is
    // pushed. A pop in the same cycle frees a slot, keeping 1 ptr/cycle.
    assign pop        = pkt_valid_o & pkt_ready_i;
    assign push       = inflight_vld & voq_valid_i[inflight_src];
    assign reserved   = fifo_cnt + {1'b0, inflight_vld};
    assign credit_ok  = (reserved < 2'd2) | ((reserved == 2'd2) & pop);
    assign issue      = grant_any & credit_ok;
    assign voq_read_o = issue ? grant_oh : '0;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (eligible),
        .advance      (issue),
        .grant_onehot (grant_oh),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // Occupancy mirror. A write to a full VOQ is discarded by the VOQ too,
    // unless a read frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            drop_o <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                drop_o[i] <= voq_write_i[i] & full[i] & ~voq_read_o[i];
                if (voq_write_i[i] & ~voq_read_o[i] & ~full[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (~voq_write_i[i] & voq_read_o[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // In-flight tracker: the response is only taken from the VOQ we read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_vld <= 1'b0;
            inflight_src <= '0;
            proto_err_o  <= 1'b0;
        end else begin
            inflight_vld <= issue;
            inflight_src <= grant_idx;
            if (|(voq_valid_i & ~expect_vld))
                proto_err_o <= 1'b1;
        end
    end

    always_comb begin
        cap_entry       = '0;
        cap_entry.ptr   = voq_ptr_i[inflight_src];
        cap_entry.flood = voq_flood_i[inflight_src];
        cap_entry.src   = inflight_src;
    end

    // 2-entry output FIFO; credit guarantees no push while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push)
                fifo_mem[fifo_wr] <= cap_entry;
            fifo_wr <= fifo_wr ^ push;
            fifo_rd <= fifo_rd ^ pop;
            if (push & ~pop)
                fifo_cnt <= fifo_cnt + 2'd1;
            else if (~push & pop)
                fifo_cnt <= fifo_cnt - 2'd1;
        end
    end

    assign head        = fifo_mem[fifo_rd];
    assign pkt_ptr_o   = head.ptr;
    assign pkt_flood_o = head.flood;
    assign pkt_src_o   = head.src;
    assign pkt_valid_o = (fifo_cnt != 2'd0);

endmodule
